// File: rtl/qreg_pkg.sv
// qreg_pkg: shared types and constants for the register read multiplexer.
//   qreg_state_e  - read-path FSM state encoding
//   COLL_W        - width of the saturating collision counter
//   TMO_W         - width of the WAIT-state timeout counter
//   TMO_DEFAULT   - default WAIT-state timeout in cycles
//   idx_width()   - index width for an N-entry select (at least 1 bit)
package qreg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } qreg_state_e;

    localparam int COLL_W      = 8;
    localparam int TMO_W       = 8;
    localparam int TMO_DEFAULT = 255;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qreg_prio_enc.sv
// qreg_prio_enc: lowest-index-wins priority encoder.
//   req_i    [N-1:0]  request / match vector
//   idx_o    [IW-1:0] index of the lowest set bit (0 when none set)
//   onehot_o [N-1:0]  one-hot of the lowest set bit (0 when none set)
//   any_o             at least one bit set
//   multi_o           two or more bits set
module qreg_prio_enc
    import qreg_pkg::*;
#(
    parameter  int N  = 5,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o,
    output logic          any_o,
    output logic          multi_o
);

    // Scan from the top down so the last (lowest) set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

    // x & -x isolates the lowest set bit; x & (x-1) clears it.
    assign onehot_o = req_i & (~req_i + N'(1));
    assign any_o    = |req_i;
    assign multi_o  = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/qreg_mux.sv
// qreg_mux: register read-data multiplexer between a bus slave FSM and
// NDEV register-owning channels (channel 0 is the config block).
//   clk            single clock, rising edge
//   reset_n        synchronous active-low reset
//   dev_match      per-channel address-match flags
//   dev_rdata      per-channel read data, channel i at [i*DW +: DW]
//   dev_ready      per-channel read-data-valid
//   rd_req         single-cycle read-start pulse
//   clr_stats      clears collision_cnt
//   addr_match     OR of dev_match (combinational)
//   dev_rd_strobe  one-hot read strobe, asserted in the accepting cycle
//   rd_ack         single-cycle completion pulse
//   rd_err         qualifies rd_ack, high on timeout
//   rd_data        registered read data, held until the next completion
//   collision_cnt  saturating count of reads accepted with multiple matches
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for rd_req with an address match
// ST_WAIT | strobe issued; waiting for dev_ready[sel], timeout or abort
module qreg_mux
    import qreg_pkg::*;
#(
    parameter int NDEV = 5,
    parameter int DW   = 16,
    parameter int TMO  = TMO_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NDEV-1:0]    dev_match,
    input  logic [NDEV*DW-1:0] dev_rdata,
    input  logic [NDEV-1:0]    dev_ready,
    input  logic               rd_req,
    input  logic               clr_stats,
    output logic               addr_match,
    output logic [NDEV-1:0]    dev_rd_strobe,
    output logic               rd_ack,
    output logic               rd_err,
    output logic [DW-1:0]      rd_data,
    output logic [COLL_W-1:0]  collision_cnt
);

    localparam int              IW       = idx_width(NDEV);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    qreg_state_e        state_q, state_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [DW-1:0]      data_q, data_d;
    logic [COLL_W-1:0]  coll_q, coll_d;

    logic [IW-1:0]      enc_idx;
    logic [NDEV-1:0]    enc_onehot;
    logic               enc_any;
    logic               enc_multi;
    logic               accept;
    logic [DW-1:0]      sel_rdata;

    qreg_prio_enc #(.N(NDEV)) u_prio_enc (
        .req_i    (dev_match),
        .idx_o    (enc_idx),
        .onehot_o (enc_onehot),
        .any_o    (enc_any),
        .multi_o  (enc_multi)
    );

    assign addr_match = enc_any;
    assign accept     = (state_q == ST_IDLE) && rd_req && enc_any;
    assign sel_rdata  = dev_rdata[int'(sel_q) * DW +: DW];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        data_d        = data_q;
        dev_rd_strobe = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d   = enc_idx;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                    // Strobe is combinational so the channel sees it in the
                    // request cycle; gate it so reset forces it low.
                    dev_rd_strobe = enc_onehot & {NDEV{reset_n}};
                end
            end
            ST_WAIT: begin
                if (!dev_match[sel_q]) begin
                    // Master abandoned the bus cycle: drop it silently.
                    state_d = ST_IDLE;
                end else if (dev_ready[sel_q]) begin
                    // Ready is checked before timeout so it wins a tie.
                    ack_d   = 1'b1;
                    data_d  = sel_rdata;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    data_d  = '1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        coll_d = coll_q;
        if (clr_stats) begin
            coll_d = '0;
        end else if (accept && enc_multi && (coll_q != '1)) begin
            coll_d = coll_q + COLL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            coll_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
            coll_q  <= coll_d;
        end
    end

    assign rd_ack        = ack_q;
    assign rd_err        = err_q;
    assign rd_data       = data_q;
    assign collision_cnt = coll_q;

endmodule

// File: tb/tb_qreg_mux.sv
// tb_qreg_mux: self-checking bench for qreg_mux (NDEV=5, DW=16, TMO=10).
module tb_qreg_mux;

    localparam int NDEV = 5;
    localparam int DW   = 16;
    localparam int TMO  = 10;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NDEV-1:0]    dev_match;
    logic [NDEV*DW-1:0] dev_rdata;
    logic [NDEV-1:0]    dev_ready;
    logic               rd_req;
    logic               clr_stats;
    logic               addr_match;
    logic [NDEV-1:0]    dev_rd_strobe;
    logic               rd_ack;
    logic               rd_err;
    logic [DW-1:0]      rd_data;
    logic [7:0]         collision_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_coll = 0;

    qreg_mux #(.NDEV(NDEV), .DW(DW), .TMO(TMO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dev_match     (dev_match),
        .dev_rdata     (dev_rdata),
        .dev_ready     (dev_ready),
        .rd_req        (rd_req),
        .clr_stats     (clr_stats),
        .addr_match    (addr_match),
        .dev_rd_strobe (dev_rd_strobe),
        .rd_ack        (rd_ack),
        .rd_err        (rd_err),
        .rd_data       (rd_data),
        .collision_cnt (collision_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [NDEV-1:0] m);
        for (int i = 0; i < NDEV; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic idle_inputs;
        dev_match = '0;
        dev_ready = '0;
        rd_req    = 1'b0;
        clr_stats = 1'b0;
    endtask

    // One complete read. k = cycle (1 = first WAIT cycle) where the selected
    // channel raises ready; any k outside 1..TMO means it never does.
    task automatic do_read(input logic [NDEV-1:0] m, input int k, input logic [DW-1:0] d,
                           input bit noise, input bit clr, input string tag);
        int s;
        int ack_c;
        bit hit;
        logic [NDEV-1:0] oh;
        logic [DW-1:0]   exp_data;
        s        = lowest(m);
        oh       = NDEV'(1) << s;
        hit      = (k >= 1) && (k <= TMO);
        ack_c    = hit ? k + 1 : TMO + 1;
        exp_data = hit ? d : {DW{1'b1}};

        tick;
        dev_match = m;
        rd_req    = 1'b1;
        clr_stats = clr;
        for (int i = 0; i < NDEV; i++) dev_rdata[i*DW +: DW] = DW'($urandom);
        dev_rdata[s*DW +: DW] = d;
        dev_ready = noise ? (NDEV'($urandom) & ~oh) : '0;
        @(negedge clk);
        n_cmp++;
        if (dev_rd_strobe !== oh) begin
            n_fail++;
            $display("FAIL %s strobe: got %b want %b", tag, dev_rd_strobe, oh);
        end
        n_cmp++;
        if (addr_match !== 1'b1) begin
            n_fail++;
            $display("FAIL %s addr_match: got %b want 1", tag, addr_match);
        end
        if (clr) model_coll = 0;
        else if ($countones(m) >= 2 && model_coll < 255) model_coll++;

        for (int c = 1; c <= ack_c; c++) begin
            tick;
            clr_stats = 1'b0;
            rd_req    = (c < ack_c) && noise && ((c == 1) || ($urandom_range(0, 1) == 1));
            dev_ready = noise ? (NDEV'($urandom) & ~oh) : '0;
            if (c == k) dev_ready[s] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (dev_rd_strobe !== '0) begin
                n_fail++;
                $display("FAIL %s strobe_in_wait c=%0d: got %b want 0", tag, c, dev_rd_strobe);
            end
            n_cmp++;
            if (rd_ack !== (c == ack_c)) begin
                n_fail++;
                $display("FAIL %s ack c=%0d: got %b want %b", tag, c, rd_ack, (c == ack_c));
            end
            if (c == ack_c) begin
                n_cmp++;
                if (rd_err !== !hit) begin
                    n_fail++;
                    $display("FAIL %s err: got %b want %b", tag, rd_err, !hit);
                end
                n_cmp++;
                if (rd_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL %s data: got %h want %h", tag, rd_data, exp_data);
                end
            end else begin
                n_cmp++;
                if (rd_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s err_without_ack c=%0d: got %b want 0", tag, c, rd_err);
                end
            end
        end

        tick;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (rd_ack !== 1'b0 || rd_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s hold: got ack=%b data=%h want ack=0 data=%h", tag, rd_ack, rd_data, exp_data);
        end
        n_cmp++;
        if (collision_cnt !== 8'(model_coll)) begin
            n_fail++;
            $display("FAIL %s coll: got %0d want %0d", tag, collision_cnt, model_coll);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (rd_ack !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0 ||
            dev_rd_strobe !== '0 || collision_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: got ack=%b err=%b data=%h strobe=%b coll=%0d want all 0",
                     tag, rd_ack, rd_err, rd_data, dev_rd_strobe, collision_cnt);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        dev_rdata = '0;
        tick;
        tick;
        @(negedge clk);
        check_reset_outputs("reset");
        n_cmp++;
        if (addr_match !== 1'b0) begin
            n_fail++;
            $display("FAIL reset addr_match: got %b want 0", addr_match);
        end
        tick;
        reset_n = 1'b1;
        model_coll = 0;
    endtask

    task automatic test_basic;
        do_read(5'b00100, 3, 16'h1234, 1'b0, 1'b0, "basic_ch2");
        do_read(5'b00001, 1, 16'hBEEF, 1'b0, 1'b0, "min_latency");
    endtask

    task automatic test_timeout;
        do_read(5'b00001, 0, 16'h5555, 1'b0, 1'b0, "timeout");
        do_read(5'b01000, TMO, 16'h0F0F, 1'b0, 1'b0, "ready_tmo_tie");
        do_read(5'b01000, TMO + 1, 16'h0F0F, 1'b1, 1'b0, "ready_late");
    endtask

    task automatic test_ignore;
        tick;
        dev_match = '0;
        rd_req    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dev_rd_strobe !== '0 || addr_match !== 1'b0) begin
            n_fail++;
            $display("FAIL nomatch_req: got strobe=%b match=%b want 0/0", dev_rd_strobe, addr_match);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            rd_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (rd_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL nomatch_ack c=%0d: got %b want 0", c, rd_ack);
            end
        end
        do_read(5'b10000, 5, 16'hA5A5, 1'b1, 1'b0, "req_in_wait");
    endtask

    task automatic test_collision_sat;
        do_read(5'b10010, 1, 16'h0001, 1'b0, 1'b0, "coll_first");
        for (int n = 0; n < 300; n++) begin
            do_read(5'b10010, 1, 16'(n), 1'b0, 1'b0, "coll_sat");
        end
        n_cmp++;
        if (collision_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL coll_saturated: got %0d want 255", collision_cnt);
        end
    endtask

    task automatic test_clr_coincide;
        do_read(5'b00110, 2, 16'hC0DE, 1'b0, 1'b1, "clr_with_incr");
        do_read(5'b00011, 2, 16'hC0DF, 1'b0, 1'b0, "incr_after_clr");
    endtask

    task automatic test_abort;
        tick;
        dev_match = 5'b01000;
        rd_req    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dev_rd_strobe !== 5'b01000) begin
            n_fail++;
            $display("FAIL abort_strobe: got %b want 01000", dev_rd_strobe);
        end
        tick;
        rd_req = 1'b0;
        tick;
        dev_match = '0;
        // Restore match with ready: a block still in WAIT would ack here.
        for (int c = 0; c < 4; c++) begin
            tick;
            dev_match = 5'b01000;
            dev_ready = 5'b01000;
            @(negedge clk);
            n_cmp++;
            if (rd_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_ack c=%0d: got %b want 0", c, rd_ack);
            end
        end
        tick;
        idle_inputs();
        do_read(5'b01000, 2, 16'h7777, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            do_read(NDEV'($urandom_range(1, 31)), $urandom_range(0, TMO + 3), DW'($urandom),
                    1'b1, ($urandom_range(0, 7) == 0), "random");
        end
    endtask

    task automatic test_reset_in_wait;
        do_read(5'b00011, 1, 16'h9999, 1'b0, 1'b0, "pre_reset");
        tick;
        dev_match = 5'b00010;
        rd_req    = 1'b1;
        tick;
        rd_req = 1'b0;
        tick;
        dev_ready = 5'b00010;
        reset_n   = 1'b0;
        tick;
        reset_n = 1'b1;
        dev_ready = '0;
        @(negedge clk);
        check_reset_outputs("reset_in_wait");
        model_coll = 0;
        tick;
        @(negedge clk);
        n_cmp++;
        if (rd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait_late_ack: got %b want 0", rd_ack);
        end
        tick;
        idle_inputs();
        do_read(5'b00010, 4, 16'h4242, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_ignore();
        test_collision_sat();
        test_clr_coincide();
        test_abort();
        test_random();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
